// File: rtl/matrix_frame_parser_pkg.sv
// Shared character codes, parser state encoding and default geometry for the
// ASCII matrix frame parser.
package matrix_frame_parser_pkg;

   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] ZERO  = 8'h30;
   localparam logic [7:0] NINE  = 8'h39;

   localparam int MAX_DIM_DEFAULT = 5;

   typedef enum logic [1:0] {
      S_M    = 2'd0,
      S_N    = 2'd1,
      S_ELEM = 2'd2,
      S_ERR  = 2'd3
   } state_t;

endpackage

// File: rtl/matrix_frame_parser_dec_accum.sv
// Decimal token accumulator: digit detect, saturating acc*10+digit, and a
// pending flag that stays set while a token has at least one digit.
module dec_accum
   import matrix_frame_parser_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              is_digit,
   output logic [DATA_W-1:0] acc,
   output logic              pending
);

   localparam int WIDE_W = DATA_W + 4;

   logic [DATA_W-1:0] acc_reg, acc_next;
   logic              pending_reg, pending_next;
   logic [WIDE_W-1:0] mac;

   assign is_digit = (rx_data >= ZERO) && (rx_data <= NINE);

   // Four spare bits hold (2^DATA_W-1)*10+9 without wrapping.
   assign mac = (WIDE_W'(acc_reg) * WIDE_W'(10)) + WIDE_W'(rx_data[3:0]);

   always_comb begin
      acc_next     = acc_reg;
      pending_next = pending_reg;
      if (rx_valid) begin
         if (is_digit) begin
            pending_next = 1'b1;
            acc_next     = (|mac[WIDE_W-1:DATA_W]) ? '1 : mac[DATA_W-1:0];
         end else if (rx_data != LF) begin
            // Any other byte ends the token; the top consumes acc this cycle.
            pending_next = 1'b0;
            acc_next     = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg     <= '0;
         pending_reg <= 1'b0;
      end else begin
         acc_reg     <= acc_next;
         pending_reg <= pending_next;
      end
   end

   assign acc     = acc_reg;
   assign pending = pending_reg;

endmodule

// File: rtl/matrix_frame_parser.sv
// ASCII "M N e0 .. ek CR [LF]" frame parser emitting row-major element writes.
// Optional range checking of dimensions/elements: define PARSER_RANGE_CHECK_EN.
module matrix_frame_parser
   import matrix_frame_parser_pkg::*;
#(
   parameter int MAX_DIM  = MAX_DIM_DEFAULT,
   parameter int DATA_W   = 8,
   parameter int ELEM_MAX = 9
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [2:0]        dim_m,
   output logic [2:0]        dim_n,
   output logic              elem_we,
   output logic [4:0]        elem_idx,
   output logic [DATA_W-1:0] elem_data,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   if (MAX_DIM < 1 || MAX_DIM > 7) begin : g_max_dim_guard
      $error("MAX_DIM must fit the 3-bit dimension outputs");
   end
   if (ELEM_MAX < 0 || ELEM_MAX >= (1 << DATA_W)) begin : g_elem_max_guard
      $error("ELEM_MAX must be representable in DATA_W bits");
   end

   state_t            state_reg, state_next;
   logic [5:0]        count_reg, count_next;
   logic [2:0]        dim_m_reg, dim_m_next;
   logic [2:0]        dim_n_reg, dim_n_next;
   logic              elem_we_reg, elem_we_next;
   logic [4:0]        elem_idx_reg, elem_idx_next;
   logic [DATA_W-1:0] elem_data_reg, elem_data_next;
   logic              frame_done_reg, frame_done_next;
   logic              frame_err_reg, frame_err_next;

   logic              is_digit, pending;
   logic [DATA_W-1:0] acc;
   logic              is_space, is_cr, is_lf, is_other;
   logic              dim_bad, elem_bad;
   logic [5:0]        total, count_inc, count_after;
   logic              token_ok;

   dec_accum #(
      .DATA_W   (DATA_W)
   ) u_dec_accum (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .is_digit (is_digit),
      .acc      (acc),
      .pending  (pending)
   );

   assign is_space  = (rx_data == SPACE);
   assign is_cr     = (rx_data == CR);
   assign is_lf     = (rx_data == LF);
   assign is_other  = !(is_digit || is_space || is_cr || is_lf);
   assign total     = {3'b000, dim_m_reg} * {3'b000, dim_n_reg};
   assign count_inc = count_reg + 6'd1;

`ifdef PARSER_RANGE_CHECK_EN
   assign dim_bad  = (acc == '0) || (acc > DATA_W'(MAX_DIM));
   assign elem_bad = (acc > DATA_W'(ELEM_MAX));
`else
   // Dimensions keep only their low three bits; a zero result is still illegal.
   assign dim_bad  = (acc[2:0] == 3'd0);
   assign elem_bad = 1'b0;
`endif

   always_comb begin
      state_next      = state_reg;
      count_next      = count_reg;
      dim_m_next      = dim_m_reg;
      dim_n_next      = dim_n_reg;
      elem_we_next    = 1'b0;
      elem_idx_next   = elem_idx_reg;
      elem_data_next  = elem_data_reg;
      frame_done_next = 1'b0;
      frame_err_next  = 1'b0;
      token_ok        = 1'b1;
      count_after     = count_reg;

      if (rx_valid && !is_lf) begin
         case (state_reg)
            S_M, S_N: begin
               if (is_cr) begin
                  frame_err_next = 1'b1;
                  state_next     = S_M;
               end else if (is_other) begin
                  frame_err_next = 1'b1;
                  state_next     = S_ERR;
               end else if (is_space && pending) begin
                  if (dim_bad) begin
                     frame_err_next = 1'b1;
                     state_next     = S_ERR;
                  end else if (state_reg == S_M) begin
                     dim_m_next = acc[2:0];
                     state_next = S_N;
                  end else begin
                     dim_n_next = acc[2:0];
                     count_next = 6'd0;
                     state_next = S_ELEM;
                  end
               end
            end

            S_ELEM: begin
               if (is_other) begin
                  frame_err_next = 1'b1;
                  state_next     = S_ERR;
               end else if (is_space || is_cr) begin
                  if (pending) begin
                     if ((count_reg == total) || elem_bad) begin
                        token_ok = 1'b0;
                     end else begin
                        elem_we_next   = 1'b1;
                        elem_idx_next  = count_reg[4:0];
                        elem_data_next = acc;
                        count_after    = count_inc;
                     end
                  end
                  count_next = count_after;
                  // A rejected token on CR already closes the frame, so skip S_ERR.
                  if (!token_ok) begin
                     frame_err_next = 1'b1;
                     state_next     = is_cr ? S_M : S_ERR;
                  end else if (is_cr) begin
                     if (count_after == total) begin
                        frame_done_next = 1'b1;
                     end else begin
                        frame_err_next = 1'b1;
                     end
                     state_next = S_M;
                  end
               end
            end

            S_ERR: begin
               if (is_cr) begin
                  state_next = S_M;
               end
            end

            default: begin
               state_next = S_M;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_M;
         count_reg      <= '0;
         dim_m_reg      <= '0;
         dim_n_reg      <= '0;
         elem_we_reg    <= 1'b0;
         elem_idx_reg   <= '0;
         elem_data_reg  <= '0;
         frame_done_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         dim_m_reg      <= dim_m_next;
         dim_n_reg      <= dim_n_next;
         elem_we_reg    <= elem_we_next;
         elem_idx_reg   <= elem_idx_next;
         elem_data_reg  <= elem_data_next;
         frame_done_reg <= frame_done_next;
         frame_err_reg  <= frame_err_next;
      end
   end

   assign dim_m      = dim_m_reg;
   assign dim_n      = dim_n_reg;
   assign elem_we    = elem_we_reg;
   assign elem_idx   = elem_idx_reg;
   assign elem_data  = elem_data_reg;
   assign frame_done = frame_done_reg;
   assign frame_err  = frame_err_reg;
   assign busy       = (state_reg != S_M) || pending;

endmodule

// File: tb/tb_matrix_frame_parser.sv
// Self-checking bench: directed and random frames scored against a
// token-level reference model, including output timing relative to bytes.
module tb_matrix_frame_parser;
   import matrix_frame_parser_pkg::*;

   localparam int MAX_DIM  = 5;
   localparam int DATA_W   = 8;
   localparam int ELEM_MAX = 9;
   localparam int SAT      = (1 << DATA_W) - 1;

   typedef logic [7:0] u8_t;
   typedef struct {
      int kind;   // 0 write, 1 done, 2 err
      int idx;
      int data;
      int t;      // byte position (expected) or cycle (observed)
   } ev_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [2:0]        dim_m, dim_n;
   logic              elem_we;
   logic [4:0]        elem_idx;
   logic [DATA_W-1:0] elem_data;
   logic              frame_done, frame_err, busy;

   matrix_frame_parser #(
      .MAX_DIM    (MAX_DIM),
      .DATA_W     (DATA_W),
      .ELEM_MAX   (ELEM_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .dim_m      (dim_m),
      .dim_n      (dim_n),
      .elem_we    (elem_we),
      .elem_idx   (elem_idx),
      .elem_data  (elem_data),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  mod_m = 0;
   int  mod_n = 0;
   ev_t exp_q[$];
   ev_t obs_q[$];
   int  byte_cyc[$];
   u8_t gen_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (elem_we)    obs_q.push_back('{0, int'(elem_idx), int'(elem_data), cyc});
      if (frame_done) obs_q.push_back('{1, 0, 0, cyc});
      if (frame_err)  obs_q.push_back('{2, 0, 0, cyc});
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int observed, input int expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_dim_bad(input int v);
`ifdef PARSER_RANGE_CHECK_EN
      return (v == 0) || (v > MAX_DIM);
`else
      return (v % 8) == 0;
`endif
   endfunction

   function automatic bit model_elem_bad(input int v);
`ifdef PARSER_RANGE_CHECK_EN
      return v > ELEM_MAX;
`else
      return (v < 0);
`endif
   endfunction

   function automatic void push_exp(input int kind, input int idx, input int data, input int pos);
      exp_q.push_back('{kind, idx % 32, data, pos});
   endfunction

   function automatic void model(input u8_t q[$], input int base);
      int  tok, written, val, pos;
      bit  have, dead, ok;
      u8_t c;
      tok = 0; written = 0; val = 0; have = 0; dead = 0;
      for (int i = 0; i < q.size(); i++) begin
         c   = q[i];
         pos = base + i;
         if (c == LF) continue;
         if (c == CR) begin
            if (!dead) begin
               if (tok < 2) begin
                  push_exp(2, 0, 0, pos);
               end else begin
                  ok = 1;
                  if (have) begin
                     if (written == mod_m * mod_n || model_elem_bad(val)) ok = 0;
                     else begin push_exp(0, written, val, pos); written++; end
                  end
                  if (ok && written == mod_m * mod_n) push_exp(1, 0, 0, pos);
                  else push_exp(2, 0, 0, pos);
               end
            end
            tok = 0; written = 0; val = 0; have = 0; dead = 0;
         end else if (dead) begin
            // discarding until end of line
         end else if (c >= ZERO && c <= NINE) begin
            val  = val * 10 + int'(c - ZERO);
            if (val > SAT) val = SAT;
            have = 1;
         end else if (c == SPACE) begin
            if (have) begin
               if (tok < 2) begin
                  if (model_dim_bad(val)) begin push_exp(2, 0, 0, pos); dead = 1; end
                  else if (tok == 0) mod_m = val % 8;
                  else mod_n = val % 8;
               end else if (written == mod_m * mod_n || model_elem_bad(val)) begin
                  push_exp(2, 0, 0, pos); dead = 1;
               end else begin
                  push_exp(0, written, val, pos); written++;
               end
               tok++;
            end
            have = 0; val = 0;
         end else begin
            push_exp(2, 0, 0, pos);
            dead = 1;
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic load(input string s, input bit add_cr, input bit add_lf);
      gen_q.delete();
      for (int i = 0; i < s.len(); i++) gen_q.push_back(u8_t'(s[i]));
      if (add_cr) gen_q.push_back(CR);
      if (add_lf) gen_q.push_back(LF);
   endtask

   task automatic push_num(input int v);
      string s;
      s = $sformatf("%0d", v);
      for (int i = 0; i < s.len(); i++) gen_q.push_back(u8_t'(s[i]));
   endtask

   task automatic drive_one(input u8_t b, input bit b2b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      byte_cyc.push_back(cyc);
      if (!b2b) begin
         @(negedge clk);
         rx_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic check_events();
      check("ev_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("ev%0d_kind", i), obs_q[i].kind, exp_q[i].kind);
         check($sformatf("ev%0d_idx", i),  obs_q[i].idx,  exp_q[i].idx);
         check($sformatf("ev%0d_data", i), obs_q[i].data, exp_q[i].data);
         check($sformatf("ev%0d_cycle", i), obs_q[i].t, byte_cyc[exp_q[i].t] + 1);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic settle_check(input string tag);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_events();
      check({tag, "_dim_m"}, int'(dim_m), mod_m);
      check({tag, "_dim_n"}, int'(dim_n), mod_n);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   task automatic run_frame(input string tag, input bit b2b);
      model(gen_q, byte_cyc.size());
      for (int i = 0; i < gen_q.size(); i++) drive_one(gen_q[i], b2b);
      settle_check(tag);
      $display("frame %s bytes=%0d b2b=%0d dims=%0dx%0d", tag, gen_q.size(), b2b, dim_m, dim_n);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dim_m"},      int'(dim_m), 0);
      check({tag, "_dim_n"},      int'(dim_n), 0);
      check({tag, "_elem_we"},    int'(elem_we), 0);
      check({tag, "_elem_idx"},   int'(elem_idx), 0);
      check({tag, "_elem_data"},  int'(elem_data), 0);
      check({tag, "_frame_done"}, int'(frame_done), 0);
      check({tag, "_frame_err"},  int'(frame_err), 0);
      check({tag, "_busy"},       int'(busy), 0);
   endtask

   task automatic gen_random();
      int m, n, cnt, r;
      gen_q.delete();
      r = $urandom_range(0, 9);
      m = (r == 0) ? 0 : (r == 1) ? 9 : $urandom_range(1, 5);
      r = $urandom_range(0, 9);
      n = (r == 0) ? 0 : (r == 1) ? 9 : $urandom_range(1, 5);
      cnt = (m % 8) * (n % 8);
      r = $urandom_range(0, 7);
      if (r == 0) cnt = cnt + 1;
      else if (r == 1 && cnt > 0) cnt = cnt - 1;
      if ($urandom_range(0, 4) == 0) gen_q.push_back(SPACE);
      push_num(m);
      repeat ($urandom_range(1, 2)) gen_q.push_back(SPACE);
      push_num(n);
      for (int k = 0; k < cnt; k++) begin
         repeat ($urandom_range(1, 2)) gen_q.push_back(SPACE);
         if ($urandom_range(0, 24) == 0) gen_q.push_back(8'h78);
         if ($urandom_range(0, 15) == 0) push_num(300);
         else push_num($urandom_range(0, 12));
      end
      if ($urandom_range(0, 3) == 0) gen_q.push_back(SPACE);
      gen_q.push_back(CR);
      if ($urandom_range(0, 1) == 1) gen_q.push_back(LF);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset");

      load("2 2 1 2 3 4", 1, 1);        run_frame("basic_2x2", 0);
      load("3  2 5 6 7 8 9 2", 1, 0);   run_frame("double_space", 0);
      load("3  2 5 6 7 8 9 2", 1, 0);   run_frame("double_space_b2b", 1);
      load("2 2 1 2 3", 1, 0);          run_frame("short_frame", 0);
      load("1 2 7 8", 1, 0);            run_frame("after_short", 1);
      load("2 x2 2 1 2 3 4", 1, 0);     run_frame("bad_char", 0);
      load("2 2 1 2 3 4", 1, 0);        run_frame("after_bad_char", 0);
      load("6 1 3", 1, 0);              run_frame("dim6", 0);
      load("1 1 12", 1, 0);             run_frame("elem12", 1);
      load("9 1 3", 1, 0);              run_frame("dim9", 0);
      load("0 1 1", 1, 0);              run_frame("dim_zero", 0);
      load("2", 1, 0);                  run_frame("cr_in_m", 0);
      load("3 1", 1, 0);                run_frame("cr_in_n", 1);
      load("1 1 4 5", 1, 0);            run_frame("extra_token_cr", 0);
      load("1 1 4 5 ", 1, 0);           run_frame("extra_token_sp", 0);
      load("1 1 999", 1, 0);            run_frame("saturate", 1);
      load("", 1, 1);                   run_frame("empty_line", 0);

      // busy while a leading digit is pending in S_M
      load("7", 1, 0);
      model(gen_q, byte_cyc.size());
      drive_one(gen_q[0], 0);
      check("pending_busy", int'(busy), 1);
      drive_one(gen_q[1], 0);
      settle_check("pending_cr");

      // reset in the middle of a frame, colliding with a committing byte
      load("2 2 1", 0, 0);
      model(gen_q, byte_cyc.size());
      for (int i = 0; i < gen_q.size(); i++) drive_one(gen_q[i], 0);
      @(negedge clk);
      check("mid_busy", int'(busy), 1);
      rst      = 1'b1;
      rx_valid = 1'b1;
      rx_data  = SPACE;
      @(negedge clk);
      rst      = 1'b0;
      rx_valid = 1'b0;
      check_all_zero("mid_reset");
      mod_m = 0;
      mod_n = 0;
      settle_check("post_reset");
      load("1 1 5", 1, 0);              run_frame("after_reset", 0);

      for (int f = 0; f < 40; f++) begin
         gen_random();
         run_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
